// File: rtl/regfile_decode_stage.sv
// Decode-side register file with write-to-read bypass
// and the D/E pipeline register that feeds execute.
module regfile_decode_stage #(
    parameter int word_width = 32,
    parameter int num_regs   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           InstrD,
    input  logic                  RegWriteW,
    input  logic [4:0]            RdW,
    input  logic [word_width-1:0] ResultW,
    input  logic                  StallE,
    input  logic                  FlushE,
    output logic [word_width-1:0] RD1E,
    output logic [word_width-1:0] RD2E,
    output logic [4:0]            Rs1E,
    output logic [4:0]            Rs2E,
    output logic [4:0]            RdE,
    output logic                  ValidE
);

    logic [word_width-1:0] regs [num_regs];

    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [word_width-1:0] rd1;
    logic [word_width-1:0] rd2;
    logic                  unused_instr;

    assign rs1 = InstrD[19:15];
    assign rs2 = InstrD[24:20];
    assign rd  = InstrD[11:7];

    // Opcode/funct bits are decoded elsewhere.
    assign unused_instr = ^{InstrD[31:25], InstrD[14:12], InstrD[6:0]};

    // Single write port; x0 writes are dropped so entry 0 stays zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < num_regs; i++) begin
                regs[i] <= '0;
            end
        end else if (RegWriteW && (RdW != 5'd0)) begin
            regs[RdW] <= ResultW;
        end
    end

    // Operand reads: x0 is zero, a same-cycle writeback wins over the array.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs1 == 5'd0) begin
            rd1 = '0;
        end else if (RegWriteW && (RdW == rs1)) begin
            rd1 = ResultW;
        end else begin
            rd1 = regs[rs1];
        end
        if (rs2 == 5'd0) begin
            rd2 = '0;
        end else if (RegWriteW && (RdW == rs2)) begin
            rd2 = ResultW;
        end else begin
            rd2 = regs[rs2];
        end
    end

    // D/E register: flush beats stall, stall holds, otherwise advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RD1E   <= '0;
            RD2E   <= '0;
            Rs1E   <= '0;
            Rs2E   <= '0;
            RdE    <= '0;
            ValidE <= 1'b0;
        end else if (FlushE) begin
            RD1E   <= '0;
            RD2E   <= '0;
            Rs1E   <= '0;
            Rs2E   <= '0;
            RdE    <= '0;
            ValidE <= 1'b0;
        end else if (!StallE) begin
            RD1E   <= rd1;
            RD2E   <= rd2;
            Rs1E   <= rs1;
            Rs2E   <= rs2;
            RdE    <= rd;
            ValidE <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_decode_stage.sv
// Directed vector bench for regfile_decode_stage.
// Vectors are applied on the falling edge and checked 1ns after the rising edge.
module tb_regfile_decode_stage;

    logic        clk;
    logic        reset;
    logic [31:0] InstrD;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic        StallE;
    logic        FlushE;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;
    logic [4:0]  RdE;
    logic        ValidE;

    int applied;
    int miscompares;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        we;
        logic [4:0]  rdw;
        logic [31:0] res;
        logic        stall;
        logic        flush;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [4:0]  ers1;
        logic [4:0]  ers2;
        logic [4:0]  erd;
        logic        ev;
    } vec_t;

    vec_t vecs [16];

    regfile_decode_stage #(
        .word_width(32),
        .num_regs(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .InstrD(InstrD),
        .RegWriteW(RegWriteW),
        .RdW(RdW),
        .ResultW(ResultW),
        .StallE(StallE),
        .FlushE(FlushE),
        .RD1E(RD1E),
        .RD2E(RD2E),
        .Rs1E(Rs1E),
        .Rs2E(Rs2E),
        .RdE(RdE),
        .ValidE(ValidE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_instr(input logic [4:0] rs1,
                                             input logic [4:0] rs2,
                                             input logic [4:0] rd);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
    endfunction

    task automatic check(input string name,
                         input logic [31:0] e1, input logic [31:0] e2,
                         input logic [4:0] ers1, input logic [4:0] ers2,
                         input logic [4:0] erd, input logic ev);
        logic [79:0] got;
        logic [79:0] exp;
        got = {RD1E, RD2E, Rs1E, Rs2E, RdE, ValidE};
        exp = {e1, e2, ers1, ers2, erd, ev};
        applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got RD1E=%h RD2E=%h Rs1E=%0d Rs2E=%0d RdE=%0d ValidE=%b, want RD1E=%h RD2E=%h Rs1E=%0d Rs2E=%0d RdE=%0d ValidE=%b",
                     name, RD1E, RD2E, Rs1E, Rs2E, RdE, ValidE,
                     e1, e2, ers1, ers2, erd, ev);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic we,
                         input logic [4:0] rdw, input logic [31:0] res,
                         input logic stall, input logic flush);
        InstrD    = mk_instr(rs1, rs2, rd);
        RegWriteW = we;
        RdW       = rdw;
        ResultW   = res;
        StallE    = stall;
        FlushE    = flush;
    endtask

    initial begin
        // rs1 rs2 rd we rdw res stall flush | e1 e2 ers1 ers2 erd ev
        vecs[0]  = '{5'd5, 5'd6, 5'd1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0,
                     32'h0, 32'h0, 5'd5, 5'd6, 5'd1, 1'b1};
        vecs[1]  = '{5'd0, 5'd0, 5'd2, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 1'b0,
                     32'h0, 32'h0, 5'd0, 5'd0, 5'd2, 1'b1};
        vecs[2]  = '{5'd3, 5'd3, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0,
                     32'hDEADBEEF, 32'hDEADBEEF, 5'd3, 5'd3, 5'd4, 1'b1};
        vecs[3]  = '{5'd7, 5'd3, 5'd5, 1'b1, 5'd7, 32'h1234, 1'b0, 1'b0,
                     32'h1234, 32'hDEADBEEF, 5'd7, 5'd3, 5'd5, 1'b1};
        vecs[4]  = '{5'd7, 5'd0, 5'd6, 1'b0, 5'd7, 32'h9999, 1'b0, 1'b0,
                     32'h1234, 32'h0, 5'd7, 5'd0, 5'd6, 1'b1};
        vecs[5]  = '{5'd0, 5'd7, 5'd8, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0,
                     32'h0, 32'h1234, 5'd0, 5'd7, 5'd8, 1'b1};
        vecs[6]  = '{5'd0, 5'd0, 5'd1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0,
                     32'h0, 32'h0, 5'd0, 5'd0, 5'd1, 1'b1};
        vecs[7]  = '{5'd3, 5'd7, 5'd9, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1,
                     32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0};
        vecs[8]  = '{5'd3, 5'd7, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0,
                     32'hDEADBEEF, 32'h1234, 5'd3, 5'd7, 5'd9, 1'b1};
        vecs[9]  = '{5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0,
                     32'hDEADBEEF, 32'h1234, 5'd3, 5'd7, 5'd9, 1'b1};
        vecs[10] = '{5'd4, 5'd5, 5'd6, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0,
                     32'hDEADBEEF, 32'h1234, 5'd3, 5'd7, 5'd9, 1'b1};
        vecs[11] = '{5'd0, 5'd3, 5'd7, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0,
                     32'hDEADBEEF, 32'h1234, 5'd3, 5'd7, 5'd9, 1'b1};
        vecs[12] = '{5'd9, 5'd0, 5'd10, 1'b1, 5'd9, 32'h55, 1'b1, 1'b0,
                     32'hDEADBEEF, 32'h1234, 5'd3, 5'd7, 5'd9, 1'b1};
        vecs[13] = '{5'd9, 5'd0, 5'd10, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0,
                     32'h55, 32'h0, 5'd9, 5'd0, 5'd10, 1'b1};
        vecs[14] = '{5'd9, 5'd9, 5'd11, 1'b1, 5'd9, 32'hAA, 1'b0, 1'b0,
                     32'hAA, 32'hAA, 5'd9, 5'd9, 5'd11, 1'b1};
        vecs[15] = '{5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1,
                     32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0};

        applied     = 0;
        miscompares = 0;
        reset       = 1'b1;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].we,
                  vecs[i].rdw, vecs[i].res, vecs[i].stall, vecs[i].flush);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2,
                  vecs[i].ers1, vecs[i].ers2, vecs[i].erd, vecs[i].ev);
        end

        // Committed writes readable straight from the array.
        @(negedge clk);
        drive(5'd3, 5'd9, 5'd12, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("array_read", 32'hDEADBEEF, 32'hAA, 5'd3, 5'd9, 5'd12, 1'b1);

        // Reset between edges clears outputs without a clock edge.
        #1;
        reset = 1'b1;
        #1;
        check("async_reset", 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        drive(5'd3, 5'd9, 5'd12, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("post_reset_file", 32'h0, 32'h0, 5'd3, 5'd9, 5'd12, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 applied, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_decode_stage.md
Name: regfile_decode_stage

Overview:
- Consumer end of the writeback interface: accepts ResultW/RegWriteW/RdW from the writeback stage and commits them to a 32x32 integer register file.
- Serves the decode stage's two source-operand reads with same-cycle write-to-read bypass.
- Registers the operands and register indices into the D/E pipeline register that feeds execute.
- Sits between fetch/decode and the execute stage of the 5-stage pipeline.

Parameters:
- word_width, 32, data width of registers, ResultW, RD1E, RD2E
- num_regs, 32, architectural register count; x0 hardwired to zero; index width fixed at 5

Ports:
- clk  input  1  pipeline clock, rising-edge
- reset  input  1  asynchronous, active-high; clears register file and D/E register
- InstrD  input  32  decode-stage instruction; rs1=[19:15], rs2=[24:20], rd=[11:7]
- RegWriteW  input  1  writeback write enable
- RdW  input  5  writeback destination index
- ResultW  input  word_width  writeback data
- StallE  input  1  hold D/E register contents
- FlushE  input  1  load bubble into D/E register
- RD1E  output  word_width  registered rs1 operand
- RD2E  output  word_width  registered rs2 operand
- Rs1E  output  5  registered rs1 index (for hazard unit)
- Rs2E  output  5  registered rs2 index
- RdE  output  5  registered rd index
- ValidE  output  1  1 = real instruction in E, 0 = bubble

Behaviour:
- Clock and reset: one clock, clk; reset asynchronous and active-high. While reset is high, all registers x1..x31 = 0 and RD1E = RD2E = 0, Rs1E = Rs2E = RdE = 0, ValidE = 0, independent of clk.
- Register-file write:
  - On rising clk edge, if RegWriteW=1 and RdW!=0, reg[RdW] <= ResultW.
  - Writes to x0 are discarded.
  - One write port only.
- Register-file read (combinational, internal):
  - rd1 = 0 if rs1==0.
  - Otherwise rd1 = ResultW if RegWriteW=1 and RdW==rs1 (bypass).
  - Otherwise rd1 = reg[rs1]. rd2 is identical using rs2.
  - Bypass guarantees an instruction in D sees a value written by the instruction in W in the same cycle.
- D/E register, evaluated on each rising clk edge, priority order:
  1. FlushE=1: RD1E=RD2E=0, Rs1E=Rs2E=RdE=0, ValidE=0. Flush wins over stall.
  2. StallE=1: all E outputs hold.
  3. Otherwise: RD1E<=rd1, RD2E<=rd2, Rs1E<=rs1, Rs2E<=rs2, RdE<=rd, ValidE<=1.
- Latency:
  - InstrD to E outputs: 1 cycle.
  - Write commit: visible to a direct array read from the next cycle on.
  - Write commit: visible via bypass in the same cycle.
- Stall with concurrent write: the register-file write still commits. Held RD1E/RD2E do not refresh; hazard/forwarding logic resolves this.
- Reset deasserted mid-pipeline: the first edge after deassertion behaves normally. The file starts all-zero; no partial state.
- Widths: no arithmetic; indices are 5 bits; no out-of-range index is possible.

Test Plan:
- Reset, then InstrD with rs1=5, rs2=6, no writes: one edge later RD1E=0, RD2E=0, Rs1E=5, Rs2E=6, ValidE=1. Assert reset mid-cycle: all E outputs 0 immediately, without a clk edge.
- Write x3=0xDEADBEEF (RegWriteW=1, RdW=3). Next cycle InstrD rs1=3, rs2=3: RD1E=RD2E=0xDEADBEEF.
- Same-cycle bypass: RegWriteW=1, RdW=7, ResultW=0x1234 while InstrD rs1=7. Next edge RD1E=0x1234. With RegWriteW=0 in the same setup, RD1E = old x7.
- Write x0=0xFFFFFFFF, including in the same cycle as an rs1=0 read: RD1E=0 then, and on any later read of x0.
- FlushE=1 and StallE=1 together with valid InstrD: after the edge ValidE=0 and all E fields 0. StallE=1 alone for 3 cycles while InstrD changes: E outputs unchanged for those 3 cycles.
- Stall with write: StallE=1, write x9=0x55, InstrD rs1=9. RD1E holds its old value during the stall. After StallE drops, next edge RD1E=0x55.
